dfd_apb_cmd_seq: RTL and testbench
==================================

DFD_APB_CMD_SEQ -- requirements
Module: dfd_apb_cmd_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 23: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width; PSTRB width = DATA_WIDTH/8.
REQ-003 SHALL have parameter CMD_DEPTH, default 8: command FIFO entries, power of two, >= 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum ACCESS-phase cycles waiting on pready.
REQ-005 SHALL have parameter MAX_POLL, default 16: maximum APB transfers per POLL command.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports i_cmd_valid input 1 and o_cmd_ready output 1: command push handshake.
REQ-009 SHALL have ports i_cmd_op input 2 (0=WRITE, 1=READ, 2=POLL, 3=reserved), i_cmd_addr input ADDR_WIDTH, i_cmd_wdata input DATA_WIDTH (write data / poll expected value), i_cmd_mask input DATA_WIDTH (poll compare mask), i_cmd_strb input DATA_WIDTH/8.
REQ-010 SHALL have ports o_rsp_valid output 1, i_rsp_ready input 1, o_rsp_rdata output DATA_WIDTH, o_rsp_err output 1, o_rsp_timeout output 1, o_rsp_attempts output $clog2(MAX_POLL+1).
REQ-011 SHALL have APB master ports paddr output ADDR_WIDTH, psel output 1, penable output 1, pstrb output DATA_WIDTH/8, pwrite output 1, pwdata output DATA_WIDTH, pready input 1, prdata input DATA_WIDTH, pslverr input 1.
REQ-012 SHALL have ports o_busy output 1 (FSM not IDLE or FIFO non-empty) and o_cmd_count output $clog2(CMD_DEPTH+1).

Function
REQ-013 SHALL buffer commands in an in-order FIFO; push on i_cmd_valid & o_cmd_ready; o_cmd_ready = (count < CMD_DEPTH).
REQ-014 SHALL run FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all APB outputs registered.
REQ-015 IDLE with FIFO non-empty SHALL pop the head into working registers and enter SETUP next cycle; a command pushed into an empty FIFO at cycle N drives psel=1, penable=0 at N+1 and penable=1 at N+2.
REQ-016 SETUP SHALL last exactly one cycle; ACCESS SHALL hold paddr/pwrite/pwdata/pstrb stable until the clk edge sampling pready=1.
REQ-017 Writes SHALL drive pwrite=1, pstrb=i_cmd_strb; READ/POLL SHALL drive pwrite=0, pstrb=0, pwdata=0.
REQ-018 On completion edge SHALL drop psel and penable in the next cycle, capture prdata (reads) and pslverr, enter RESP.
REQ-019 POLL SHALL complete when (prdata & mask) == (wdata & mask) or pslverr=1; otherwise SHALL re-enter SETUP the next cycle with psel low for exactly that one cycle between transfers... specifically psel deasserts one cycle (IDLE-gap) then SETUP; after MAX_POLL unmatched transfers SHALL complete with o_rsp_err=1, o_rsp_timeout=1.
REQ-020 ACCESS exceeding TIMEOUT_CYCLES cycles with pready=0 SHALL abort: psel/penable low next cycle, RESP with err=1, timeout=1, rdata=0.
REQ-021 o_rsp_err SHALL equal pslverr OR timeout; o_rsp_attempts SHALL count APB transfers issued (1 for WRITE/READ).
REQ-022 RESP SHALL hold o_rsp_valid=1 and payload stable until i_rsp_ready; on handshake go IDLE; no new transfer while a response is pending.
REQ-023 Reserved op SHALL issue no APB transfer and respond err=1, timeout=0, attempts=0 via RESP.
REQ-024 Push while FIFO full SHALL be ignored (o_cmd_ready=0); push and pop in same cycle SHALL keep count unchanged; pointers wrap modulo CMD_DEPTH.

Reset
REQ-025 reset_n low SHALL immediately force psel, penable, pwrite, paddr, pwdata, pstrb, o_rsp_* , o_busy, o_cmd_count to 0, o_cmd_ready to 1, FSM to IDLE, FIFO empty.
REQ-026 Reset asserted mid-ACCESS SHALL drop psel combinationally-free (via async flop clear) and discard the in-flight command without response.

Verification
REQ-027 WRITE addr 0x000248 data 0xDEADBEEF strb 0xF, pready=1 -> psel at N+1, penable N+2, o_rsp_valid N+3, err=0, attempts=1.
REQ-028 READ addr 0x166040, pready low 3 ACCESS cycles, prdata=0xBEEFDEAD -> penable high 4 cycles, pstrb=0, o_rsp_rdata=0xBEEFDEAD.
REQ-029 POLL mask 0x1 expect 0x1, prdata 0,0,1 -> 3 APB transfers, err=0, attempts=3; with prdata stuck 0 and MAX_POLL=4 -> attempts=4, err=1, timeout=1.
REQ-030 TIMEOUT_CYCLES=16, pready stuck 0 -> psel drops after 16 ACCESS cycles, err=1, timeout=1, rdata=0.
REQ-031 i_rsp_ready=0, push CMD_DEPTH+2 commands -> o_cmd_ready low at count=CMD_DEPTH, extra push dropped, responses return in push order once ready=1.
REQ-032 reset_n low during ACCESS -> all APB outputs 0 same cycle, o_cmd_count=0, no response after release.

Source files
------------

// File: rtl/dfd_apb_cmd_seq.sv
// APB command sequencer: buffers WRITE/READ/POLL commands in a FIFO and executes
// them one at a time as APB master transfers, returning one response per command.
module dfd_apb_cmd_seq #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_POLL       = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [1:0]                     i_cmd_op,
  input  logic [ADDR_WIDTH-1:0]          i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]          i_cmd_wdata,
  input  logic [DATA_WIDTH-1:0]          i_cmd_mask,
  input  logic [DATA_WIDTH/8-1:0]        i_cmd_strb,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [DATA_WIDTH-1:0]          o_rsp_rdata,
  output logic                           o_rsp_err,
  output logic                           o_rsp_timeout,
  output logic [$clog2(MAX_POLL+1)-1:0]  o_rsp_attempts,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic                           psel,
  output logic                           penable,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic                           pready,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pslverr,
  output logic                           o_busy,
  output logic [$clog2(CMD_DEPTH+1)-1:0] o_cmd_count
);

  // state  | meaning
  // IDLE   | waiting for a command; pops FIFO head (or bypasses an incoming push)
  // SETUP  | APB setup phase, psel=1 penable=0
  // ACCESS | APB access phase, waiting on pready with timeout down-counter
  // GAP    | one idle cycle with psel low between POLL transfers
  // RESP   | response held until i_rsp_ready

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int ATT_W  = $clog2(MAX_POLL + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP, ST_RESP} state_t;

  state_t state;

  logic [1:0]            fifo_op    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mask  [CMD_DEPTH];
  logic [STRB_W-1:0]     fifo_strb  [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cmd_count;
  logic             fifo_empty, push, pop;

  logic [1:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata, head_mask;
  logic [STRB_W-1:0]     head_strb;

  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_wdata, w_mask;
  logic [ATT_W-1:0]      attempts;
  logic [TMR_W-1:0]      tmr;
  logic                  poll_match;

  assign fifo_empty  = (cmd_count == '0);
  assign o_cmd_ready = (cmd_count < CNT_W'(CMD_DEPTH));
  assign push        = i_cmd_valid & o_cmd_ready;
  // An empty FIFO in IDLE hands the incoming command straight to the FSM so the
  // transfer starts the cycle after the push.
  assign pop         = (state == ST_IDLE) & (~fifo_empty | push);
  assign o_cmd_count = cmd_count;
  assign o_busy      = (state != ST_IDLE) | ~fifo_empty;

  assign head_op    = fifo_empty ? i_cmd_op    : fifo_op[rd_ptr];
  assign head_addr  = fifo_empty ? i_cmd_addr  : fifo_addr[rd_ptr];
  assign head_wdata = fifo_empty ? i_cmd_wdata : fifo_wdata[rd_ptr];
  assign head_mask  = fifo_empty ? i_cmd_mask  : fifo_mask[rd_ptr];
  assign head_strb  = fifo_empty ? i_cmd_strb  : fifo_strb[rd_ptr];

  assign poll_match = ((prdata ^ w_wdata) & w_mask) == '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]    <= i_cmd_op;
      fifo_addr[wr_ptr]  <= i_cmd_addr;
      fifo_wdata[wr_ptr] <= i_cmd_wdata;
      fifo_mask[wr_ptr]  <= i_cmd_mask;
      fifo_strb[wr_ptr]  <= i_cmd_strb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + CNT_W'(1);
        2'b01:   cmd_count <= cmd_count - CNT_W'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      paddr          <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pstrb          <= '0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      o_rsp_valid    <= 1'b0;
      o_rsp_rdata    <= '0;
      o_rsp_err      <= 1'b0;
      o_rsp_timeout  <= 1'b0;
      o_rsp_attempts <= '0;
      w_op           <= '0;
      w_wdata        <= '0;
      w_mask         <= '0;
      attempts       <= '0;
      tmr            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            w_op    <= head_op;
            w_wdata <= head_wdata;
            w_mask  <= head_mask;
            if (head_op == OP_RSVD) begin
              o_rsp_valid    <= 1'b1;
              o_rsp_rdata    <= '0;
              o_rsp_err      <= 1'b1;
              o_rsp_timeout  <= 1'b0;
              o_rsp_attempts <= '0;
              state          <= ST_RESP;
            end else begin
              paddr    <= head_addr;
              psel     <= 1'b1;
              penable  <= 1'b0;
              pwrite   <= (head_op == OP_WRITE);
              pwdata   <= (head_op == OP_WRITE) ? head_wdata : '0;
              pstrb    <= (head_op == OP_WRITE) ? head_strb : '0;
              attempts <= ATT_W'(1);
              state    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          tmr     <= TMR_W'(TIMEOUT_CYCLES - 1);
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if ((w_op == OP_POLL) && !pslverr && !poll_match &&
                (attempts != ATT_W'(MAX_POLL))) begin
              state <= ST_GAP;
            end else begin
              o_rsp_valid    <= 1'b1;
              o_rsp_rdata    <= (w_op == OP_WRITE) ? '0 : prdata;
              o_rsp_err      <= pslverr | ((w_op == OP_POLL) & ~poll_match);
              o_rsp_timeout  <= (w_op == OP_POLL) & ~pslverr & ~poll_match;
              o_rsp_attempts <= attempts;
              state          <= ST_RESP;
            end
          end else if (tmr == '0) begin
            psel           <= 1'b0;
            penable        <= 1'b0;
            o_rsp_valid    <= 1'b1;
            o_rsp_rdata    <= '0;
            o_rsp_err      <= 1'b1;
            o_rsp_timeout  <= 1'b1;
            o_rsp_attempts <= attempts;
            state          <= ST_RESP;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_GAP: begin
          psel     <= 1'b1;
          attempts <= attempts + ATT_W'(1);
          state    <= ST_SETUP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfd_apb_cmd_seq.sv
// Directed bench for dfd_apb_cmd_seq with a small programmable APB slave model.
module tb_dfd_apb_cmd_seq;
  localparam int AW = 23, DW = 32, DEPTH = 8, TMO = 16, MPOLL = 4;

  logic clk = 1'b0, reset_n;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_mask;
  logic [3:0] cmd_strb;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [2:0] rsp_attempts;
  logic [AW-1:0] paddr;
  logic psel, penable, pwrite, pready, pslverr, busy;
  logic [3:0] pstrb;
  logic [DW-1:0] pwdata, prdata;
  logic [3:0] cmd_count;

  // slave model controls
  logic [7:0] slv_wait;
  logic slv_stuck, slv_err, addr_mode;
  logic [DW-1:0] slv_rdata [8];
  int acc_cyc, xfer_cnt = 0, pen_cyc = 0, psel_cyc = 0, xfer_base;
  logic [2:0] sidx;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  dfd_apb_cmd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
                    .TIMEOUT_CYCLES(TMO), .MAX_POLL(MPOLL)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_mask(cmd_mask),
    .i_cmd_strb(cmd_strb), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_rsp_attempts(rsp_attempts), .paddr(paddr), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .o_busy(busy), .o_cmd_count(cmd_count)
  );

  assign sidx    = 3'(xfer_cnt - xfer_base);
  assign pready  = psel && penable && !slv_stuck && (acc_cyc >= int'(slv_wait));
  assign pslverr = pready && slv_err;
  assign prdata  = addr_mode ? (32'hA500_0000 | 32'(paddr)) : slv_rdata[sidx];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_cyc <= 0;
    else if (psel && penable) acc_cyc <= pready ? 0 : acc_cyc + 1;
    else acc_cyc <= 0;
  end

  always @(posedge clk) begin
    if (psel) psel_cyc <= psel_cyc + 1;
    if (psel && penable) pen_cyc <= pen_cyc + 1;
    if (psel && penable && pready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_push(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] m, input logic [3:0] s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_strb = s;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for o_rsp_valid; reports cycles since the push edge and
  // what the APB bus carried while psel was high.
  task automatic wait_rsp(output int cyc, output logic [3:0] strb_or,
                          output logic wr_or, output logic [DW-1:0] wd_or);
    cyc = 0; strb_or = '0; wr_or = 1'b0; wd_or = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (psel) begin strb_or |= pstrb; wr_or |= pwrite; wd_or |= pwdata; end
      if (rsp_valid) return;
    end
    chk("rsp_wait_expired", 64'(rsp_valid), 64'(1));
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  int cyc, p0, x0, acc;
  logic [3:0] s_or;
  logic w_or, v_or;
  logic [DW-1:0] d_or;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; cmd_strb = '0; rsp_ready = 1'b0;
    slv_wait = 8'd0; slv_stuck = 1'b0; slv_err = 1'b0; addr_mode = 1'b0; xfer_base = 0;
    for (int i = 0; i < 8; i++) slv_rdata[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_count", 64'(cmd_count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;

    // WRITE, zero wait states: psel N+1, penable N+2, response N+3
    do_push(2'd0, 23'h000248, 32'hDEADBEEF, 32'h0, 4'hF);
    @(negedge clk);
    chk("wr_setup_psel", 64'(psel), 64'(1));
    chk("wr_setup_pen", 64'(penable), 64'(0));
    @(negedge clk);
    chk("wr_acc_pen", 64'(penable), 64'(1));
    chk("wr_paddr", 64'(paddr), 64'h000248);
    chk("wr_pwdata", 64'(pwdata), 64'hDEADBEEF);
    chk("wr_pstrb", 64'(pstrb), 64'hF);
    chk("wr_pwrite", 64'(pwrite), 64'(1));
    @(negedge clk);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_psel_drop", 64'(psel), 64'(0));
    chk("wr_err", 64'(rsp_err), 64'(0));
    chk("wr_attempts", 64'(rsp_attempts), 64'(1));
    ack_rsp();
    @(negedge clk);
    chk("wr_rsp_drop", 64'(rsp_valid), 64'(0));

    // READ with 3 wait states
    slv_wait = 8'd3; slv_rdata[0] = 32'hBEEFDEAD;
    xfer_base = xfer_cnt; p0 = pen_cyc;
    do_push(2'd1, 23'h166040, 32'h1234_5678, 32'h0, 4'hF);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("rd_latency", 64'(cyc), 64'(6));
    chk("rd_pen_cycles", 64'(pen_cyc - p0), 64'(4));
    chk("rd_pstrb", 64'(s_or), 64'(0));
    chk("rd_pwrite", 64'(w_or), 64'(0));
    chk("rd_pwdata", 64'(d_or), 64'(0));
    chk("rd_rdata", 64'(rsp_rdata), 64'hBEEFDEAD);
    chk("rd_err", 64'(rsp_err), 64'(0));
    ack_rsp();

    // POLL matching on third transfer
    slv_wait = 8'd0; slv_rdata[0] = 32'h0; slv_rdata[1] = 32'h0; slv_rdata[2] = 32'h1;
    xfer_base = xfer_cnt; x0 = xfer_cnt; p0 = psel_cyc;
    do_push(2'd2, 23'h000100, 32'h1, 32'h1, 4'hF);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("poll_latency", 64'(cyc), 64'(9));
    chk("poll_xfers", 64'(xfer_cnt - x0), 64'(3));
    chk("poll_psel_cycles", 64'(psel_cyc - p0), 64'(6));
    chk("poll_attempts", 64'(rsp_attempts), 64'(3));
    chk("poll_err", 64'(rsp_err), 64'(0));
    chk("poll_rdata", 64'(rsp_rdata), 64'(1));
    ack_rsp();

    // POLL never matching: exhausts MAX_POLL
    slv_rdata[2] = 32'h0; slv_rdata[3] = 32'h0;
    xfer_base = xfer_cnt; x0 = xfer_cnt;
    do_push(2'd2, 23'h000100, 32'h1, 32'h1, 4'hF);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("pollx_latency", 64'(cyc), 64'(12));
    chk("pollx_xfers", 64'(xfer_cnt - x0), 64'(4));
    chk("pollx_attempts", 64'(rsp_attempts), 64'(4));
    chk("pollx_err", 64'(rsp_err), 64'(1));
    chk("pollx_timeout", 64'(rsp_timeout), 64'(1));
    ack_rsp();

    // WRITE with slave error
    slv_err = 1'b1;
    do_push(2'd0, 23'h000010, 32'h5, 32'h0, 4'h3);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("slverr_err", 64'(rsp_err), 64'(1));
    chk("slverr_timeout", 64'(rsp_timeout), 64'(0));
    ack_rsp();
    slv_err = 1'b0;

    // ACCESS timeout
    slv_stuck = 1'b1; slv_rdata[0] = 32'hFFFF_FFFF; xfer_base = xfer_cnt; p0 = pen_cyc;
    do_push(2'd1, 23'h000020, 32'h0, 32'h0, 4'h0);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("tmo_latency", 64'(cyc), 64'(18));
    chk("tmo_pen_cycles", 64'(pen_cyc - p0), 64'(16));
    chk("tmo_psel", 64'(psel), 64'(0));
    chk("tmo_err", 64'(rsp_err), 64'(1));
    chk("tmo_timeout", 64'(rsp_timeout), 64'(1));
    chk("tmo_rdata", 64'(rsp_rdata), 64'(0));
    ack_rsp();
    slv_stuck = 1'b0;

    // Reserved op: no APB transfer
    p0 = psel_cyc;
    do_push(2'd3, 23'h000030, 32'h0, 32'h0, 4'h0);
    wait_rsp(cyc, s_or, w_or, d_or);
    chk("rsvd_latency", 64'(cyc), 64'(1));
    chk("rsvd_no_psel", 64'(psel_cyc - p0), 64'(0));
    chk("rsvd_err", 64'(rsp_err), 64'(1));
    chk("rsvd_timeout", 64'(rsp_timeout), 64'(0));
    chk("rsvd_attempts", 64'(rsp_attempts), 64'(0));
    ack_rsp();

    // FIFO fill with responses back-pressured
    addr_mode = 1'b1; acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 23'(i + 1);
      if (cmd_ready) acc++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", 64'(acc), 64'(DEPTH + 1));
    chk("fill_count", 64'(cmd_count), 64'(DEPTH));
    chk("fill_ready_low", 64'(cmd_ready), 64'(0));
    chk("fill_busy", 64'(busy), 64'(1));
    for (int k = 0; k < DEPTH + 1; k++) begin
      wait_rsp(cyc, s_or, w_or, d_or);
      chk($sformatf("order_rdata_%0d", k), 64'(rsp_rdata), 64'(32'hA500_0000 | (k + 1)));
      ack_rsp();
    end
    v_or = 1'b0;
    repeat (8) begin @(negedge clk); v_or |= rsp_valid; end
    chk("drop_no_rsp", 64'(v_or), 64'(0));
    chk("drain_count", 64'(cmd_count), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));
    addr_mode = 1'b0;

    // Reset in the middle of ACCESS with one command queued
    slv_stuck = 1'b1;
    do_push(2'd1, 23'h000040, 32'h0, 32'h0, 4'h0);
    do_push(2'd0, 23'h000044, 32'h77, 32'h0, 4'hF);
    @(negedge clk);
    chk("mid_acc_pen", 64'(psel & penable), 64'(1));
    chk("mid_acc_count", 64'(cmd_count), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("arst_psel", 64'(psel), 64'(0));
    chk("arst_penable", 64'(penable), 64'(0));
    chk("arst_paddr", 64'(paddr), 64'(0));
    chk("arst_pwdata", 64'(pwdata), 64'(0));
    chk("arst_count", 64'(cmd_count), 64'(0));
    chk("arst_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    reset_n = 1'b1; slv_stuck = 1'b0; p0 = psel_cyc; v_or = 1'b0;
    repeat (20) begin @(negedge clk); v_or |= rsp_valid; end
    chk("arst_no_rsp", 64'(v_or), 64'(0));
    chk("arst_no_xfer", 64'(psel_cyc - p0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end
endmodule
